// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module  : fetch_unit
// Brief   : Instruction fetch stage: req/ack memory read, valid/ready hand-off,
//           branch-redirect kill and HLT stop.
// Revision: 1.0
// ============================================================================
module fetch_unit #(
    parameter int         ADDR_W     = 16,
    parameter int         DATA_W     = 16,
    parameter logic [3:0] HLT_OPCODE = 4'hF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] pc,
    input  logic              redirect,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] instr,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic              pc_adv,
    output logic              halted,
    output logic [15:0]       fetch_count
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_WAIT   = 3'd1,
        S_DRAIN  = 3'd2,
        S_HOLD   = 3'd3,
        S_HALTED = 3'd4
    } state_t;

    state_t              state_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   instr_q;
    logic [15:0]         fetch_count_q;
    logic [15:0]         fetch_count_d;
    logic                mem_req_q;
    logic                instr_valid_q;
    logic                halted_q;
    logic                hlt_op;

    assign hlt_op        = (instr_q[15:12] == HLT_OPCODE);
    assign fetch_count_d = fetch_count_q + 16'd1;

    // Status outputs are registered copies of the state so they never glitch.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            addr_q        <= '0;
            instr_q       <= '0;
            fetch_count_q <= '0;
            mem_req_q     <= 1'b0;
            instr_valid_q <= 1'b0;
            halted_q      <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    addr_q    <= pc;
                    state_q   <= S_WAIT;
                    mem_req_q <= 1'b1;
                end
                S_WAIT: begin
                    if (mem_ack && !redirect) begin
                        instr_q       <= mem_rdata;
                        state_q       <= S_HOLD;
                        mem_req_q     <= 1'b0;
                        instr_valid_q <= 1'b1;
                    end else if (mem_ack) begin
                        state_q   <= S_IDLE;
                        mem_req_q <= 1'b0;
                    end else if (redirect) begin
                        state_q <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    // The memory still owes us a beat; absorb it before refetching.
                    if (mem_ack) begin
                        state_q   <= S_IDLE;
                        mem_req_q <= 1'b0;
                    end
                end
                S_HOLD: begin
                    if (redirect) begin
                        state_q       <= S_IDLE;
                        instr_valid_q <= 1'b0;
                    end else if (instr_ready) begin
                        fetch_count_q <= fetch_count_d;
                        instr_valid_q <= 1'b0;
                        if (hlt_op) begin
                            state_q  <= S_HALTED;
                            halted_q <= 1'b1;
                        end else begin
                            state_q <= S_IDLE;
                        end
                    end
                end
                S_HALTED: begin
                    state_q <= S_HALTED;
                end
                default: begin
                    state_q       <= S_IDLE;
                    mem_req_q     <= 1'b0;
                    instr_valid_q <= 1'b0;
                    halted_q      <= 1'b0;
                end
            endcase
        end
    end

    assign mem_req     = mem_req_q;
    assign mem_addr    = addr_q;
    assign instr       = instr_q;
    assign instr_valid = instr_valid_q;
    assign halted      = halted_q;
    assign fetch_count = fetch_count_q;
    // HLT is consumed without advancing the PC.
    assign pc_adv      = instr_valid_q & instr_ready & ~redirect & ~hlt_op;

endmodule

`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// tb_fetch_unit: directed fetch scenarios checked every cycle against a
// transaction-level reference model, plus hand-computed spot values.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] pc = '0;
    logic        redirect = 1'b0;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_ack = 1'b0;
    logic [15:0] mem_rdata = '0;
    logic [15:0] instr;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic        pc_adv;
    logic        halted;
    logic [15:0] fetch_count;

    int vectors = 0;
    int miscompares = 0;

    fetch_unit #(.ADDR_W(16), .DATA_W(16), .HLT_OPCODE(4'hF)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .pc          (pc),
        .redirect    (redirect),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata),
        .instr       (instr),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .pc_adv      (pc_adv),
        .halted      (halted),
        .fetch_count (fetch_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- memory responder: acks after ack_delay idle request cycles
    int          ack_delay = 0;
    logic [15:0] mem_data = '0;
    int          wcnt = 0;

    always @(posedge clk) begin
        #1;
        if (!rst_n) begin
            mem_ack = 1'b0;
            wcnt    = 0;
        end else if (mem_ack) begin
            mem_ack = 1'b0;
        end else if (mem_req) begin
            if (wcnt >= ack_delay) begin
                mem_ack   = 1'b1;
                mem_rdata = mem_data;
                wcnt      = 0;
            end else begin
                wcnt++;
            end
        end
    end

    // ---------------- reference model: what the fetch stage is doing, not how
    logic        m_live = 1'b0;
    logic        m_idle = 1'b0;   // next edge launches a fetch from pc
    logic        m_req = 1'b0;    // a memory read is outstanding
    logic        m_drop = 1'b0;   // the outstanding read was killed
    logic        m_valid = 1'b0;  // an instruction is on offer
    logic        m_halt = 1'b0;
    logic [15:0] m_addr = '0;
    logic [15:0] m_instr = '0;
    int          m_cnt = 0;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_live = 1'b1; m_idle = 1'b1; m_req = 1'b0; m_drop = 1'b0;
            m_valid = 1'b0; m_halt = 1'b0; m_addr = '0; m_instr = '0; m_cnt = 0;
        end else if (m_live && !m_halt) begin
            if (m_idle) begin
                m_addr = pc;
                m_idle = 1'b0;
                m_req  = 1'b1;
                m_drop = 1'b0;
            end else if (m_req) begin
                if (mem_ack) begin
                    m_req = 1'b0;
                    if (m_drop || redirect) m_idle = 1'b1;
                    else begin
                        m_instr = mem_rdata;
                        m_valid = 1'b1;
                    end
                    m_drop = 1'b0;
                end else if (redirect) begin
                    m_drop = 1'b1;
                end
            end else if (m_valid) begin
                if (redirect) begin
                    m_valid = 1'b0;
                    m_idle  = 1'b1;
                end else if (instr_ready) begin
                    m_cnt   = (m_cnt + 1) % 65536;
                    m_valid = 1'b0;
                    if (m_instr[15:12] == 4'hF) m_halt = 1'b1;
                    else m_idle = 1'b1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (m_live) begin
            check("mem_req",     {31'd0, mem_req},     {31'd0, m_req});
            check("mem_addr",    {16'd0, mem_addr},    {16'd0, m_addr});
            check("instr_valid", {31'd0, instr_valid}, {31'd0, m_valid});
            check("instr",       {16'd0, instr},       {16'd0, m_instr});
            check("halted",      {31'd0, halted},      {31'd0, m_halt});
            check("fetch_count", {16'd0, fetch_count}, {16'd0, m_cnt[15:0]});
            check("pc_adv", {31'd0, pc_adv},
                  {31'd0, m_valid & instr_ready & ~redirect & (m_instr[15:12] != 4'hF)});
        end
    end

    // ---------------- directed scenarios
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input string name);
        int n = 0;
        @(negedge clk);
        while (instr_valid !== 1'b1 && n < 60) begin
            @(negedge clk);
            n++;
        end
        check(name, {31'd0, instr_valid}, 32'd1);
    endtask

    initial begin
        int req_n;
        int n;
        logic saw_old;

        tick(); tick();
        @(negedge clk);
        check("rst_mem_req", {31'd0, mem_req}, 32'd0);
        check("rst_valid",   {31'd0, instr_valid}, 32'd0);
        check("rst_count",   {16'd0, fetch_count}, 32'd0);
        check("rst_halted",  {31'd0, halted}, 32'd0);

        // 1: single fetch, immediate ack, ready held high
        tick();
        mem_data = 16'h1234; ack_delay = 0; instr_ready = 1'b1; rst_n = 1'b1;
        wait_valid("t1_valid");
        check("t1_instr",  {16'd0, instr}, 32'h1234);
        check("t1_pc_adv", {31'd0, pc_adv}, 32'd1);
        check("t1_addr",   {16'd0, mem_addr}, 32'h0000);
        tick();
        instr_ready = 1'b0;
        check("t1_count",    {16'd0, fetch_count}, 32'd1);
        check("t1_adv_once", {31'd0, pc_adv}, 32'd0);

        // 2: slow memory, request must stay up at a stable address
        pc = 16'h0040; ack_delay = 5; mem_data = 16'h2222;
        req_n = 0; n = 0;
        @(negedge clk);
        while (instr_valid !== 1'b1 && n < 60) begin
            if (mem_req === 1'b1 && mem_addr === 16'h0040) req_n++;
            n++;
            @(negedge clk);
        end
        check("t2_req_cycles", req_n, 32'd6);
        check("t2_instr", {16'd0, instr}, 32'h2222);
        tick(); instr_ready = 1'b1;
        tick(); instr_ready = 1'b0;
        check("t2_one_hold", {31'd0, instr_valid}, 32'd0);
        check("t2_count", {16'd0, fetch_count}, 32'd2);

        // 3: redirect while the read is outstanding
        pc = 16'h0080; ack_delay = 3; mem_data = 16'hAAAA;
        tick(); redirect = 1'b1; pc = 16'h0100;
        tick(); redirect = 1'b0;
        saw_old = 1'b0; n = 0;
        @(negedge clk);
        while (!(mem_req === 1'b1 && mem_addr === 16'h0100) && n < 60) begin
            if (instr_valid === 1'b1) saw_old = 1'b1;
            n++;
            @(negedge clk);
        end
        check("t3_no_old_valid", {31'd0, saw_old}, 32'd0);
        check("t3_new_addr", {16'd0, mem_addr}, 32'h0100);
        mem_data = 16'hBBBB;
        wait_valid("t3_valid");
        check("t3_instr", {16'd0, instr}, 32'hBBBB);
        check("t3_count", {16'd0, fetch_count}, 32'd2);

        // 4: redirect and ready together in HOLD; redirect wins
        mem_data = 16'h3333; ack_delay = 1;
        tick(); instr_ready = 1'b1; redirect = 1'b1; pc = 16'h0200;
        @(negedge clk);
        check("t4_pc_adv", {31'd0, pc_adv}, 32'd0);
        tick(); instr_ready = 1'b0; redirect = 1'b0;
        check("t4_count", {16'd0, fetch_count}, 32'd2);
        check("t4_valid_drop", {31'd0, instr_valid}, 32'd0);
        wait_valid("t4_valid");
        check("t4_addr",  {16'd0, mem_addr}, 32'h0200);
        check("t4_instr", {16'd0, instr}, 32'h3333);

        // 6a: counter wrap, preloaded to the last value before wrap
        tick();
        dut.fetch_count_q = 16'hFFFF;
        m_cnt = 32'h0000FFFF;
        instr_ready = 1'b1;
        tick(); instr_ready = 1'b0;
        check("t6_wrap", {16'd0, fetch_count}, 32'h0000);

        // 6b: reset in the middle of a read
        pc = 16'h0300; ack_delay = 4;
        tick();
        check("t6_in_wait", {31'd0, mem_req}, 32'd1);
        rst_n = 1'b0;
        tick();
        check("t6_rst_req",   {31'd0, mem_req}, 32'd0);
        check("t6_rst_valid", {31'd0, instr_valid}, 32'd0);
        check("t6_rst_instr", {16'd0, instr}, 32'h0000);
        check("t6_rst_addr",  {16'd0, mem_addr}, 32'h0000);

        // 5: HLT stops fetching for good
        pc = 16'h0400; mem_data = 16'hF000; ack_delay = 0; instr_ready = 1'b1; rst_n = 1'b1;
        wait_valid("t5_valid");
        check("t5_instr",  {16'd0, instr}, 32'hF000);
        check("t5_pc_adv", {31'd0, pc_adv}, 32'd0);
        tick();
        check("t5_halted", {31'd0, halted}, 32'd1);
        check("t5_count",  {16'd0, fetch_count}, 32'd1);
        for (int i = 0; i < 20; i++) begin
            tick();
            redirect = ((i % 3) == 0);
            pc = 16'h0500 + 16'(i);
            @(negedge clk);
            check("t5_no_req", {31'd0, mem_req}, 32'd0);
        end
        redirect = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, expected end before %0t", $time);
        $fatal(1);
    end

endmodule

`default_nettype wire
